// File: rtl/sync_memory_array_if.sv
// Request/response bus of the synchronous memory array.
// The master issues valid/ready requests; the slave (memory) returns
// in-order, non-backpressured responses plus its init status.
interface sync_memory_array_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic [WIDTH/8-1:0]    req_strb;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  rsp_error;
  logic                  init_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, init_done
  );
endinterface

// File: rtl/sync_memory_array.sv
// Parametrised single-port synchronous memory with byte-strobed writes,
// valid/ready requests, in-order responses after READ_LATENCY cycles,
// address range checking and a clear sweep after every reset.
module sync_memory_array #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 1
) (
  input logic                clk,
  input logic                rst,
  sync_memory_array_if.slave bus
);

  localparam int                    NBYTES    = WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);

  // Reject illegal configurations at elaboration time.
  generate
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $error("sync_memory_array: WIDTH must be a non-zero multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("sync_memory_array: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $error("sync_memory_array: DEPTH must be at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  ready_s;
  logic                  clear_s;
  logic                  accept_s;
  logic                  in_range_s;

  logic                  we_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [WIDTH-1:0]      wdata_s;
  logic [NBYTES-1:0]     wbe_s;
  logic [WIDTH-1:0]      rd_s;

  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic                  s1_valid_q;
  logic                  s1_err_q;
  logic [WIDTH-1:0]      s1_data_q;

  // FSM state and sweep counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep every word once, then run until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: clear during the sweep, accept requests once running.
  always_comb begin
    ready_s = 1'b0;
    clear_s = 1'b0;
    case (state_q)
      ST_INIT: begin
        ready_s = 1'b0;
        clear_s = 1'b1;
      end
      ST_RUN: begin
        ready_s = 1'b1;
        clear_s = 1'b0;
      end
      default: begin
        ready_s = 1'b0;
        clear_s = 1'b0;
      end
    endcase
  end

  // A reset cycle never commits a request, even if the FSM was running.
  assign accept_s   = bus.req_valid & ready_s & ~rst;
  assign in_range_s = ({1'b0, bus.req_addr} < DEPTH_CMP);

  // Single write port shared by the clear sweep and accepted writes.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = cnt_q;
    wdata_s = '0;
    wbe_s   = '0;
    if (clear_s && !rst) begin
      we_s    = 1'b1;
      waddr_s = cnt_q;
      wdata_s = '0;
      wbe_s   = '1;
    end else if (accept_s && bus.req_write && in_range_s) begin
      we_s    = 1'b1;
      waddr_s = bus.req_addr;
      wdata_s = bus.req_wdata;
      wbe_s   = bus.req_strb;
    end else begin
      we_s    = 1'b0;
    end
  end

  // Storage array: byte-granular write, no reset (cleared by the sweep).
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (wbe_s[k]) begin
          mem_q[waddr_s][k*8 +: 8] <= wdata_s[k*8 +: 8];
        end
      end
    end
  end

  // Read data: only in-range reads return array contents.
  always_comb begin
    rd_s = '0;
    if (accept_s && !bus.req_write && in_range_s) begin
      rd_s = mem_q[bus.req_addr];
    end else begin
      rd_s = '0;
    end
  end

  // First response stage, registered at the acceptance edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= accept_s;
      s1_err_q   <= accept_s & ~in_range_s;
      s1_data_q  <= rd_s;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic             s2_valid_q;
      logic             s2_err_q;
      logic [WIDTH-1:0] s2_data_q;

      // Optional output register stage after the array read.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_err_q   <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          s2_err_q   <= s1_err_q;
          s2_data_q  <= s1_data_q;
        end
      end

      assign bus.rsp_valid = s2_valid_q;
      assign bus.rsp_error = s2_err_q;
      assign bus.rsp_rdata = s2_data_q;
    end else begin : g_lat1
      assign bus.rsp_valid = s1_valid_q;
      assign bus.rsp_error = s1_err_q;
      assign bus.rsp_rdata = s1_data_q;
    end
  endgenerate

  assign bus.req_ready = ready_s;
  assign bus.init_done = ready_s;

endmodule

// File: tb/tb_sync_memory_array.sv
// Self-checking bench: two memory instances (16 words/latency 1 and
// 12 words/latency 2) share one stimulus stream and are each checked
// every cycle against a behavioural model, plus literal expectations.
module tb_sync_memory_array;

  typedef struct packed {
    int          inst;
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_memory_array_if #(.WIDTH(32), .ADDR_WIDTH(4)) bus_a ();
  sync_memory_array_if #(.WIDTH(32), .ADDR_WIDTH(4)) bus_b ();

  sync_memory_array #(.WIDTH(32), .DEPTH(16), .READ_LATENCY(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sync_memory_array #(.WIDTH(32), .DEPTH(12), .READ_LATENCY(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int          depth_m [2] = '{16, 12};
  int          lat_m   [2] = '{1, 2};
  logic [31:0] mm      [2][16];
  logic        rdy     [2];
  int          left    [2];
  rsp_t        rq[$];
  int          ecnt;
  int          passes;
  int          total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Model the effect of one clock edge given the inputs presented before it.
  task automatic model_edge(input logic r, input logic v, input logic w,
                            input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    rsp_t rsp;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        rdy[i]  = 1'b0;
        left[i] = depth_m[i];
        for (int j = 0; j < 16; j++) mm[i][j] = 32'h0;
        for (int j = rq.size() - 1; j >= 0; j--) begin
          if (rq[j].inst == i) rq.delete(j);
        end
      end else begin
        if (v && rdy[i]) begin
          rsp.inst = i;
          rsp.due  = ecnt + lat_m[i] - 1;
          rsp.err  = (int'(a) >= depth_m[i]);
          rsp.data = 32'h0;
          if (w) begin
            if (!rsp.err) begin
              for (int k = 0; k < 4; k++) begin
                if (s[k]) mm[i][a][k*8 +: 8] = d[k*8 +: 8];
              end
            end
          end else if (!rsp.err) begin
            rsp.data = mm[i][a];
          end
          rq.push_back(rsp);
        end
        if (!rdy[i]) begin
          left[i]--;
          if (left[i] == 0) rdy[i] = 1'b1;
        end
      end
    end
  endtask

  // Compare both instances against the model for the current cycle.
  task automatic compare_all();
    logic        av, ae, ar, ai, ev, ee;
    logic [31:0] ad, ed;
    int          idx;
    string       p;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "a" : "b";
      if (i == 0) begin
        av = bus_a.rsp_valid; ae = bus_a.rsp_error; ad = bus_a.rsp_rdata;
        ar = bus_a.req_ready; ai = bus_a.init_done;
      end else begin
        av = bus_b.rsp_valid; ae = bus_b.rsp_error; ad = bus_b.rsp_rdata;
        ar = bus_b.req_ready; ai = bus_b.init_done;
      end
      idx = -1;
      for (int j = rq.size() - 1; j >= 0; j--) begin
        if (rq[j].inst == i) idx = j;
      end
      ev = 1'b0; ee = 1'b0; ed = 32'h0;
      if (idx >= 0) begin
        if (rq[idx].due == ecnt) begin
          ev = 1'b1; ee = rq[idx].err; ed = rq[idx].data;
          rq.delete(idx);
        end
      end
      chk($sformatf("rsp_valid_%s", p), 32'(av), 32'(ev));
      chk($sformatf("rsp_error_%s", p), 32'(ae), 32'(ee));
      chk($sformatf("rsp_rdata_%s", p), ad, ed);
      chk($sformatf("req_ready_%s", p), 32'(ar), 32'(rdy[i]));
      chk($sformatf("init_done_%s", p), 32'(ai), 32'(rdy[i]));
    end
  endtask

  // Present one cycle of stimulus to both instances, advance, then check.
  task automatic cycle(input logic r, input logic v, input logic w,
                       input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    rst = r;
    bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a;
    bus_a.req_wdata = d; bus_a.req_strb = s;
    bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a;
    bus_b.req_wdata = d; bus_b.req_strb = s;
    ecnt++;
    model_edge(r, v, w, a, d, s);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic rd(input logic [3:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cycle(1'b0, 1'b1, 1'b1, a, d, s);
  endtask

  // Count cycles with req_ready low until both instances are running.
  task automatic count_init(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int t = 0; t < 40; t++) begin
      if (bus_a.req_ready && bus_b.req_ready) break;
      if (!bus_a.req_ready) na++;
      if (!bus_b.req_ready) nb++;
      idle();
    end
  endtask

  initial begin
    int na, nb;
    passes = 0;
    total  = 0;
    ecnt   = 0;
    for (int i = 0; i < 2; i++) begin
      rdy[i]  = 1'b0;
      left[i] = depth_m[i];
    end

    // Reset held for several cycles, then the clear sweep.
    for (int t = 0; t < 3; t++) cycle(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
    chk("reset_ready_a", 32'(bus_a.req_ready), 32'h0);
    chk("reset_valid_b", 32'(bus_b.rsp_valid), 32'h0);
    count_init(na, nb);
    chk("init_cycles_a", 32'(na), 32'd16);
    chk("init_cycles_b", 32'(nb), 32'd12);
    chk("init_done_a", 32'(bus_a.init_done), 32'h1);

    // Read of a freshly cleared word.
    rd(4'd5);
    chk("t1_valid_a", 32'(bus_a.rsp_valid), 32'h1);
    chk("t1_rdata_a", bus_a.rsp_rdata, 32'h0);
    chk("t1_valid_b_early", 32'(bus_b.rsp_valid), 32'h0);
    idle();
    chk("t1_valid_b", 32'(bus_b.rsp_valid), 32'h1);
    chk("t1_valid_a_after", 32'(bus_a.rsp_valid), 32'h0);

    // Byte-strobed merge.
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    wr(4'd3, 32'h000000AA, 4'h1);
    rd(4'd3);
    chk("t2_rdata_a", bus_a.rsp_rdata, 32'hDEADBEAA);
    idle();
    chk("t2_rdata_b", bus_b.rsp_rdata, 32'hDEADBEAA);

    // Write then read on the next cycle.
    wr(4'd7, 32'h12345678, 4'hF);
    chk("t3_wr_valid_a", 32'(bus_a.rsp_valid), 32'h1);
    chk("t3_wr_rdata_a", bus_a.rsp_rdata, 32'h0);
    rd(4'd7);
    chk("t3_rd_valid_a", 32'(bus_a.rsp_valid), 32'h1);
    chk("t3_rd_rdata_a", bus_a.rsp_rdata, 32'h12345678);
    idle();
    chk("t3_rd_rdata_b", bus_b.rsp_rdata, 32'h12345678);

    // Out-of-range addresses on the 12-word instance.
    wr(4'd13, 32'hFFFFFFFF, 4'hF);
    rd(4'd13);
    chk("t4_wr_error_b", 32'(bus_b.rsp_error), 32'h1);
    chk("t4_rd_rdata_a", bus_a.rsp_rdata, 32'hFFFFFFFF);
    rd(4'd11);
    chk("t4_rd13_error_b", 32'(bus_b.rsp_error), 32'h1);
    chk("t4_rd13_rdata_b", bus_b.rsp_rdata, 32'h0);
    idle();
    chk("t4_rd11_valid_b", 32'(bus_b.rsp_valid), 32'h1);
    chk("t4_rd11_error_b", 32'(bus_b.rsp_error), 32'h0);
    chk("t4_rd11_rdata_b", bus_b.rsp_rdata, 32'h0);

    // Back-to-back reads of a preloaded region.
    for (int j = 0; j < 8; j++) wr(4'(j), 32'(j * 32'h11), 4'hF);
    for (int t = 0; t < 9; t++) begin
      if (t < 8) rd(4'(t));
      else idle();
      if (t < 8) chk("t5_rdata_a", bus_a.rsp_rdata, 32'(t * 32'h11));
      if (t >= 1) begin
        chk("t5_valid_b", 32'(bus_b.rsp_valid), 32'h1);
        chk("t5_rdata_b", bus_b.rsp_rdata, 32'((t - 1) * 32'h11));
      end
    end

    // Reset with reads in flight, then re-clear.
    rd(4'd3);
    rd(4'd3);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    chk("t6_valid_a", 32'(bus_a.rsp_valid), 32'h0);
    chk("t6_valid_b", 32'(bus_b.rsp_valid), 32'h0);
    count_init(na, nb);
    chk("t6_init_cycles_a", 32'(na), 32'd16);
    chk("t6_init_cycles_b", 32'(nb), 32'd12);
    rd(4'd3);
    chk("t6_rdata_a", bus_a.rsp_rdata, 32'h0);
    chk("t6_rvalid_a", 32'(bus_a.rsp_valid), 32'h1);
    idle();
    chk("t6_rdata_b", bus_b.rsp_rdata, 32'h0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            32'($urandom),
            4'($urandom_range(0, 15)));
    end
    for (int t = 0; t < 3; t++) idle();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/sync_memory_array.md
Name: sync_memory_array

Overview:
Parametrised single-port synchronous memory: the next generation of the fixed 32-bit memory instance used in the macro test module. Adds configurable width, depth and read latency, byte-strobed writes, and a valid/ready request interface with in-order responses. Also adds address range checking and a hardware clear-on-reset sweep. Instantiated through the memory instantiation macro in test and IP top levels.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8 (elaboration error otherwise)
DEPTH, 16, number of words; any value >= 2, need not be a power of two
ADDR_WIDTH, $clog2(DEPTH), request address width
READ_LATENCY, 1, cycles from request acceptance to response; only 1 or 2 are legal (elaboration error otherwise)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  WIDTH  write data
req_strb  input  WIDTH/8  byte write enables; bit k covers wdata[8k+7:8k]
rsp_valid  output  1  response valid, single-cycle pulse per request
rsp_rdata  output  WIDTH  read data; 0 for writes and errors
rsp_error  output  1  address >= DEPTH
init_done  output  1  clear sweep complete

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, init_done=0; response pipeline flushed; state=INIT; sweep counter=0.
- FSM states:
  - INIT: each cycle writes 0 to mem[cnt], then cnt++. On the cycle cnt==DEPTH-1 is written, transition to RUN. INIT therefore lasts exactly DEPTH cycles after rst deasserts.
  - RUN: req_ready=1 and init_done=1 continuously. RUN is left only by rst.
- Acceptance: a request is accepted on a cycle with req_valid && req_ready. Requests in INIT are ignored; no state change.
- Responses: every accepted request produces exactly one response.
  - rsp_valid is asserted exactly READ_LATENCY cycles after the acceptance edge.
  - Responses are strictly in order. One request per cycle is sustained with no bubbles.
  - There is no response backpressure; the consumer must always accept.
- Write: for each k with req_strb[k]=1, the byte is updated at the acceptance edge; other bytes are preserved. strb=0 is a legal no-op write and still gets a response (rdata=0, error per address).
- Read: returns the array contents as they stand after all earlier-accepted writes. A write followed by a read to the same address on the next cycle returns the new data. No bypass hazard exists because the port is single.
- READ_LATENCY=2: output register stage after the array read. Pipeline stages carry valid, error and data.
- Out of range (req_addr >= DEPTH, possible only when DEPTH is not a power of two):
  - Write: dropped, memory unchanged.
  - Read: rdata=0.
  - Both: rsp_error=1 on the response.
- rsp_rdata and rsp_error are 0 whenever rsp_valid=0.
- Reset mid-operation: in-flight responses are discarded, so rsp_valid=0 from the cycle after rst is sampled high. The FSM returns to INIT and the full array is re-cleared.
- rst held high for multiple cycles: the block stays in reset state; the INIT count starts on the first cycle rst is low.

Test Plan:
1. WIDTH=32, DEPTH=16, LAT=1: release rst -> req_ready=0 for exactly 16 cycles, then init_done=1; read addr 5 -> rsp_valid one cycle later, rdata=0x00000000, error=0.
2. Write 0xDEADBEEF to addr 3 with strb=4'hF, write 0x000000AA to addr 3 with strb=4'h1, read addr 3 -> rdata=0xDEADBEAA.
3. Write 0x12345678 to addr 7, then read addr 7 on the next cycle -> rsp_valid on two consecutive cycles; the second carries rdata=0x12345678.
4. DEPTH=12: write 0xFFFFFFFF to addr 13 -> rsp_error=1; read addr 13 -> error=1, rdata=0; read addr 11 -> error=0, rdata=0.
5. LAT=2: reads of addr 0..7 issued back-to-back (pre-loaded with value = addr*0x11) -> 8 consecutive rsp_valid cycles starting 2 cycles after the first acceptance, with data 0x00, 0x11, ..., 0x77 in order.
6. Two reads in flight and rst asserted for 1 cycle -> no rsp_valid afterwards; INIT repeats for DEPTH cycles; previously written addr 3 now reads 0.
